// File: rtl/div8_seq_ctrl.sv
// Sequential unsigned restoring divider controller: DVD_W-bit dividend by DVS_W-bit divisor,
// one quotient bit per cycle through a shared external DVS_W-bit subtractor.
module div8_seq_ctrl #(
  parameter int unsigned DVD_W = 8,
  parameter int unsigned DVS_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [DVD_W-1:0] dividend_i,
  input  logic [DVS_W-1:0] divisor_i,
  output logic [DVS_W-1:0] sub_a_o,
  output logic [DVS_W-1:0] sub_b_o,
  input  logic [DVS_W-1:0] sub_dif_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [DVD_W-1:0] quotient_o,
  output logic [DVS_W-1:0] remainder_o
);

  localparam int unsigned CntW = $clog2(DVD_W);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q;
  logic [DVD_W-1:0]   dvd_q;
  logic [DVS_W-1:0]   dvs_q;
  logic [DVS_W-1:0]   rem_q;
  logic [DVD_W-1:0]   q_q;
  logic [CntW-1:0]    cnt_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic [DVD_W-1:0]   quotient_q;
  logic [DVS_W-1:0]   remainder_q;

  logic [DVS_W:0]     s;
  logic               ge;
  logic [DVS_W-1:0]   rem_nxt;
  logic [DVD_W-1:0]   q_nxt;

  assign s = {rem_q, dvd_q[cnt_q]};

  always_comb begin
    // A set carry bit means s already exceeds any DVS_W-bit divisor, and the true
    // difference fits in DVS_W bits, so the wrapped subtractor result is exact.
    ge      = s[DVS_W] | (s[DVS_W-1:0] >= dvs_q);
    rem_nxt = ge ? sub_dif_i : s[DVS_W-1:0];
    q_nxt   = q_q;
    q_nxt[cnt_q] = ge;
    sub_a_o = '0;
    sub_b_o = '0;
    if (state_q == StRun) begin
      sub_a_o = s[DVS_W-1:0];
      sub_b_o = dvs_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
          if (start_i) begin
            if (divisor_i != '0) begin
              dvd_q   <= dividend_i;
              dvs_q   <= divisor_i;
              rem_q   <= '0;
              q_q     <= '0;
              cnt_q   <= CntW'(DVD_W - 1);
              err_q   <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= StRun;
            end else begin
              err_q       <= 1'b1;
              quotient_q  <= '1;
              remainder_q <= dividend_i[DVS_W-1:0];
              done_q      <= 1'b1;
              state_q     <= StDone;
            end
          end
        end
        StRun: begin
          rem_q <= rem_nxt;
          q_q   <= q_nxt;
          if (cnt_q == '0) begin
            quotient_q  <= q_nxt;
            remainder_q <= rem_nxt;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= StDone;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;

endmodule
